// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Two-port (instruction fetch / data) arbiter in front of a
//               single asynchronous SRAM. One access at a time runs through
//               IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE. The granted
//               port gets a one-cycle ready pulse in DONE; read data is held
//               in a per-port register until that port's next read.
//
//               Compile-time option:
//                 ARB_ROUND_ROBIN_EN  - when defined, simultaneous requests
//                                       alternate between the ports (fetch
//                                       gets the first tie after reset).
//                                       When undefined, the data port always
//                                       wins a tie.
//
// Ports       : clk, rst            - clock, synchronous active-high reset
//               if_*                - fetch port (read only)
//               dm_*                - data port (load / store, active-low BE)
//               sram_*              - SRAM pins (active-low strobes)
//
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_AW     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req_i,
    input  logic [31:0]        if_addr_i,
    output logic [31:0]        if_rdata_o,
    output logic               if_ready_o,
    input  logic               dm_re_i,
    input  logic               dm_we_i,
    input  logic [31:0]        dm_addr_i,
    input  logic [3:0]         dm_wbe_n_i,
    input  logic [31:0]        dm_wdata_i,
    output logic [31:0]        dm_rdata_o,
    output logic               dm_ready_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [31:0]        sram_wdata_o,
    output logic [3:0]         sram_be_n_o,
    output logic               sram_ce_n_o,
    output logic               sram_oe_n_o,
    output logic               sram_we_n_o,
    input  logic [31:0]        sram_rdata_i
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_done   = 2'd2;

    localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [3:0]         r_cnt;
    logic               r_gnt_dm;
    logic               r_is_wr;
    logic [SRAM_AW-1:0] r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be_n;
    logic [31:0]        r_if_rdata;
    logic [31:0]        r_dm_rdata;
    logic               r_last_dm;

    logic               w_dm_req;
    logic               w_any_req;
    logic               w_grant_dm;
    logic               w_unused;

    assign w_dm_req  = dm_re_i | dm_we_i;
    assign w_any_req = if_req_i | w_dm_req;

    // Only word-address bits reach the SRAM; the last-grant flag only steers
    // arbitration in the round-robin build.
    assign w_unused = ^{if_addr_i, dm_addr_i, r_last_dm};

`ifdef ARB_ROUND_ROBIN_EN
    // r_gnt_seen stays low until the first grant so that, with the last-grant
    // flag resetting to "fetch", the very first tie still goes to fetch.
    logic r_gnt_seen;

    always_comb begin
        w_grant_dm = w_dm_req;
        if (if_req_i && w_dm_req) begin
            w_grant_dm = r_gnt_seen && !r_last_dm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt_seen <= 1'b0;
        end else if ((r_state == c_st_idle) && w_any_req) begin
            r_gnt_seen <= 1'b1;
        end
    end
`else
    assign w_grant_dm = w_dm_req;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:   if (w_any_req)       w_state_nxt = c_st_access;
            c_st_access: if (r_cnt == 4'd0)   w_state_nxt = c_st_done;
            c_st_done:                        w_state_nxt = c_st_idle;
            default:                          w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_cnt      <= 4'd0;
            r_gnt_dm   <= 1'b0;
            r_is_wr    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_be_n     <= 4'b1111;
            r_if_rdata <= 32'd0;
            r_dm_rdata <= 32'd0;
            r_last_dm  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_st_idle: begin
                    if (w_any_req) begin
                        r_cnt     <= c_wait_load;
                        r_gnt_dm  <= w_grant_dm;
                        r_is_wr   <= w_grant_dm & dm_we_i;
                        r_last_dm <= w_grant_dm;
                        if (w_grant_dm) begin
                            r_addr  <= dm_addr_i[SRAM_AW+1:2];
                            r_wdata <= dm_wdata_i;
                            // Loads enable all lanes; stores use the caller's mask.
                            r_be_n  <= dm_we_i ? dm_wbe_n_i : 4'b0000;
                        end else begin
                            r_addr  <= if_addr_i[SRAM_AW+1:2];
                            r_be_n  <= 4'b0000;
                        end
                    end
                end
                c_st_access: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (!r_is_wr) begin
                        if (r_gnt_dm) begin
                            r_dm_rdata <= sram_rdata_i;
                        end else begin
                            r_if_rdata <= sram_rdata_i;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // SRAM strobes: only active while in ACCESS
    // ------------------------------------------------------------------------
    always_comb begin
        sram_ce_n_o = 1'b1;
        sram_oe_n_o = 1'b1;
        sram_we_n_o = 1'b1;
        sram_be_n_o = 4'b1111;
        if (r_state == c_st_access) begin
            sram_ce_n_o = 1'b0;
            sram_be_n_o = r_be_n;
            if (r_is_wr) begin
                sram_we_n_o = 1'b0;
            end else begin
                sram_oe_n_o = 1'b0;
            end
        end
    end

    assign sram_addr_o  = r_addr;
    assign sram_wdata_o = r_wdata;
    assign if_rdata_o   = r_if_rdata;
    assign dm_rdata_o   = r_dm_rdata;
    assign if_ready_o   = (r_state == c_st_done) && !r_gnt_dm;
    assign dm_ready_o   = (r_state == c_st_done) &&  r_gnt_dm;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Self-checking bench for sram_arbiter. Directed vector table,
//               randomized transactions against a transaction-level model,
//               reset-abort, arbitration and zero-wait-state sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int W = 1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        if_req, dm_re, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [3:0]  dm_wbe_n;
    logic [31:0] if_rdata, dm_rdata;
    logic        if_ready, dm_ready;
    logic [19:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;
    logic [3:0]  sram_be_n;
    logic        ce_n, oe_n, we_n;

    logic        use_fixed;
    logic [31:0] fixed_val;

    // SRAM contents: a fixed function of the word address.
    function automatic logic [31:0] hashw(input logic [19:0] a);
        return {a[11:0], a} ^ 32'hA5C3_0F96;
    endfunction

    assign sram_rdata = use_fixed ? fixed_val : hashw(sram_addr);

    sram_arbiter #(.WAIT_CYCLES(W), .SRAM_AW(20)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
        .dm_re_i(dm_re), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wbe_n_i(dm_wbe_n),
        .dm_wdata_i(dm_wdata), .dm_rdata_o(dm_rdata), .dm_ready_o(dm_ready),
        .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_be_n_o(sram_be_n),
        .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n), .sram_rdata_i(sram_rdata)
    );

    // Second instance with zero wait states.
    logic        w0_if_req, w0_dm_re, w0_dm_we;
    logic [31:0] w0_if_addr, w0_dm_addr, w0_dm_wdata;
    logic [3:0]  w0_dm_wbe_n;
    logic [31:0] w0_if_rdata, w0_dm_rdata, w0_sram_wdata, w0_sram_rdata;
    logic        w0_if_ready, w0_dm_ready;
    logic [19:0] w0_sram_addr;
    logic [3:0]  w0_sram_be_n;
    logic        w0_ce_n, w0_oe_n, w0_we_n;

    assign w0_sram_rdata = hashw(w0_sram_addr);

    sram_arbiter #(.WAIT_CYCLES(0), .SRAM_AW(20)) dut_w0 (
        .clk(clk), .rst(rst),
        .if_req_i(w0_if_req), .if_addr_i(w0_if_addr), .if_rdata_o(w0_if_rdata), .if_ready_o(w0_if_ready),
        .dm_re_i(w0_dm_re), .dm_we_i(w0_dm_we), .dm_addr_i(w0_dm_addr), .dm_wbe_n_i(w0_dm_wbe_n),
        .dm_wdata_i(w0_dm_wdata), .dm_rdata_o(w0_dm_rdata), .dm_ready_o(w0_dm_ready),
        .sram_addr_o(w0_sram_addr), .sram_wdata_o(w0_sram_wdata), .sram_be_n_o(w0_sram_be_n),
        .sram_ce_n_o(w0_ce_n), .sram_oe_n_o(w0_oe_n), .sram_we_n_o(w0_we_n), .sram_rdata_i(w0_sram_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Transaction-level reference state.
    logic [31:0] m_if, m_dm;
    logic        m_last_dm, m_seen;

    task automatic model_reset();
        m_if = 32'd0; m_dm = 32'd0; m_last_dm = 1'b0; m_seen = 1'b0;
    endtask

    function automatic logic model_grant_dm(input logic iq, input logic dq);
        if (!iq) return 1'b1;
        if (!dq) return 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        // Alternate on ties; fetch has the first tie after reset.
        return m_seen && !m_last_dm;
`else
        return 1'b1;
`endif
    endfunction

    task automatic zero_inputs();
        if_req = 0; dm_re = 0; dm_we = 0; if_addr = 0; dm_addr = 0; dm_wbe_n = 4'hF; dm_wdata = 0;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "/ce_n"}, ce_n, 1'b1);
        chk({nm, "/oe_n"}, oe_n, 1'b1);
        chk({nm, "/we_n"}, we_n, 1'b1);
        chk({nm, "/be_n"}, sram_be_n, 4'hF);
        chk({nm, "/if_ready"}, if_ready, 1'b0);
        chk({nm, "/dm_ready"}, dm_ready, 1'b0);
    endtask

    // Call just after a rising edge with the DUT idle. Inputs are scrambled
    // after the sampling edge to show the access runs on latched operands.
    task automatic run_txn(input string nm, input logic iq, input logic dre, input logic dwe,
                           input logic [31:0] ia, input logic [31:0] da, input logic [3:0] wbe,
                           input logic [31:0] wd, input logic fix,
                           input logic exp_dm, input logic exp_wr, input logic [19:0] exp_addr,
                           input logic [3:0] exp_be);
        logic [31:0] exp_rd;
        use_fixed = fix;
        exp_rd = fix ? fixed_val : hashw(exp_addr);
        if_req = iq; dm_re = dre; dm_we = dwe; if_addr = ia; dm_addr = da; dm_wbe_n = wbe; dm_wdata = wd;
        @(negedge clk);
        chk_idle({nm, "/idle"});
        @(posedge clk); #1;
        m_seen = 1'b1; m_last_dm = exp_dm;
        if_req = 1'($urandom); dm_re = 1'($urandom); dm_we = 1'($urandom);
        if_addr = $urandom; dm_addr = $urandom; dm_wbe_n = 4'($urandom); dm_wdata = $urandom;
        for (int k = 0; k <= W; k++) begin
            @(negedge clk);
            chk({nm, "/acc_ce_n"}, ce_n, 1'b0);
            chk({nm, "/acc_oe_n"}, oe_n, exp_wr);
            chk({nm, "/acc_we_n"}, we_n, !exp_wr);
            chk({nm, "/acc_addr"}, sram_addr, exp_addr);
            chk({nm, "/acc_be_n"}, sram_be_n, exp_be);
            if (exp_wr) chk({nm, "/acc_wdata"}, sram_wdata, wd);
            chk({nm, "/acc_rdy"}, {if_ready, dm_ready}, 2'b00);
            chk({nm, "/acc_if_rdata"}, if_rdata, m_if);
            chk({nm, "/acc_dm_rdata"}, dm_rdata, m_dm);
            @(posedge clk);
        end
        if (!exp_wr) begin
            if (exp_dm) m_dm = exp_rd;
            else        m_if = exp_rd;
        end
        @(negedge clk);
        chk({nm, "/done_strobes"}, {ce_n, oe_n, we_n}, 3'b111);
        chk({nm, "/done_if_ready"}, if_ready, !exp_dm);
        chk({nm, "/done_dm_ready"}, dm_ready, exp_dm);
        chk({nm, "/done_if_rdata"}, if_rdata, m_if);
        chk({nm, "/done_dm_rdata"}, dm_rdata, m_dm);
        @(posedge clk); #1;
        zero_inputs();
    endtask

    typedef struct {
        logic        iq, dre, dwe;
        logic [31:0] ia, da;
        logic [3:0]  wbe;
        logic [31:0] wd;
        logic        fix;
        logic        exp_dm, exp_wr;
        logic [19:0] exp_addr;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t        vecs[7];
    logic        r_iq, r_dre, r_dwe, r_g, r_ewr;
    logic [31:0] r_ia, r_da, r_wd;
    logic [3:0]  r_wbe, r_ebe;
    logic [19:0] r_eaddr;
    int          n_if, n_dm;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        fixed_val = 32'hDEAD_BEEF;
        use_fixed = 1'b0;
        zero_inputs();
        w0_if_req = 0; w0_dm_re = 0; w0_dm_we = 0; w0_if_addr = 0; w0_dm_addr = 0;
        w0_dm_wbe_n = 4'hF; w0_dm_wdata = 0;
        model_reset();

        // ---------------- reset values ----------------
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        chk("reset/addr", sram_addr, 20'd0);
        chk("reset/wdata", sram_wdata, 32'd0);
        chk("reset/if_rdata", if_rdata, 32'd0);
        chk("reset/dm_rdata", dm_rdata, 32'd0);
        chk("reset/w0_strobes", {w0_ce_n, w0_oe_n, w0_we_n, w0_sram_be_n}, 7'h7F);
        rst = 1'b0;
        @(posedge clk); #1;

        // ---------------- directed vector table ----------------
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0,    32'h10,        4'hF,    32'h0,         1'b1, 1'b1, 1'b0, 20'h4,     4'h0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0,    32'h6,         4'b0011, 32'h1234_0000, 1'b0, 1'b1, 1'b1, 20'h1,     4'b0011};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h100,  32'h0,         4'hF,    32'h0,         1'b0, 1'b0, 1'b0, 20'h40,    4'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h2000, 32'h3004,      4'hF,    32'h0,         1'b0, 1'b1, 1'b0, 20'hC01,   4'h0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h0,    32'hFFFF_FFFC, 4'hF,    32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, 20'hFFFFF, 4'hF};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0,    32'h44,        4'b0101, 32'hA5A5_5A5A, 1'b0, 1'b1, 1'b1, 20'h11,    4'b0101};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h7,    32'h0,         4'hF,    32'h0,         1'b0, 1'b0, 1'b0, 20'h1,     4'h0};
        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].iq, vecs[i].dre, vecs[i].dwe, vecs[i].ia,
                    vecs[i].da, vecs[i].wbe, vecs[i].wd, vecs[i].fix, vecs[i].exp_dm,
                    vecs[i].exp_wr, vecs[i].exp_addr, vecs[i].exp_be);
        end

        // ---------------- randomized transactions ----------------
        for (int t = 0; t < 40; t++) begin
            r_iq = 1'($urandom); r_dre = 1'($urandom); r_dwe = 1'($urandom);
            if (!(r_iq | r_dre | r_dwe)) r_iq = 1'b1;
            r_ia = $urandom; r_da = $urandom; r_wbe = 4'($urandom); r_wd = $urandom;
            r_g     = model_grant_dm(r_iq, r_dre | r_dwe);
            r_ewr   = r_g & r_dwe;
            r_eaddr = r_g ? r_da[21:2] : r_ia[21:2];
            r_ebe   = r_ewr ? r_wbe : 4'b0000;
            run_txn($sformatf("rnd%0d", t), r_iq, r_dre, r_dwe, r_ia, r_da, r_wbe, r_wd, 1'b0,
                    r_g, r_ewr, r_eaddr, r_ebe);
        end

        // ---------------- reset in the middle of a load ----------------
        dm_re = 1'b1; dm_addr = 32'h20;
        @(posedge clk); #1;
        dm_re = 1'b0;
        @(negedge clk);
        chk("rstmid/acc1_ce_n", ce_n, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk_idle("rstmid");
        chk("rstmid/addr", sram_addr, 20'd0);
        chk("rstmid/dm_rdata", dm_rdata, 32'd0);
        chk("rstmid/if_rdata", if_rdata, 32'd0);
        @(negedge clk);
        chk("rstmid/no_late_ready", {if_ready, dm_ready}, 2'b00);
        @(posedge clk); #1;

        // ---------------- both ports held for four accesses ----------------
        if_req = 1'b1; dm_re = 1'b1; if_addr = 32'h400; dm_addr = 32'h800;
        n_if = 0; n_dm = 0;
        for (int c = 0; c < 4 * (W + 3); c++) begin
            @(negedge clk);
            if (if_ready) n_if++;
            if (dm_ready) n_dm++;
            chk("arb/ready_exclusive", {1'b0, if_ready & dm_ready}, 2'b00);
        end
        zero_inputs();
`ifdef ARB_ROUND_ROBIN_EN
        chk("arb/if_grants", n_if, 2);
        chk("arb/dm_grants", n_dm, 2);
`else
        chk("arb/if_grants", n_if, 0);
        chk("arb/dm_grants", n_dm, 4);
`endif
        @(posedge clk); #1;
        @(negedge clk);
        chk_idle("arb_end");

        // ---------------- zero wait states ----------------
        @(posedge clk); #1;
        w0_if_req = 1'b1; w0_if_addr = 32'h100;
        @(negedge clk);
        chk("w0/c0_ce_n", w0_ce_n, 1'b1);
        @(posedge clk); #1;
        w0_if_req = 1'b0;
        @(negedge clk);
        chk("w0/c1_strobes", {w0_ce_n, w0_oe_n, w0_we_n}, 3'b001);
        chk("w0/c1_addr", w0_sram_addr, 20'h40);
        chk("w0/c1_if_ready", w0_if_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("w0/c2_if_ready", w0_if_ready, 1'b1);
        chk("w0/c2_ce_n", w0_ce_n, 1'b1);
        chk("w0/c2_if_rdata", w0_if_rdata, hashw(20'h40));
        @(posedge clk); #1;
        w0_dm_re = 1'b1; w0_dm_addr = 32'h44;
        @(negedge clk);
        chk("w0/ld0_ready", {w0_if_ready, w0_dm_ready}, 2'b00);
        @(posedge clk); #1;
        w0_dm_re = 1'b0;
        @(negedge clk);
        chk("w0/ld1_strobes", {w0_ce_n, w0_oe_n, w0_we_n}, 3'b001);
        chk("w0/ld1_addr", w0_sram_addr, 20'h11);
        @(posedge clk);
        @(negedge clk);
        chk("w0/ld2_dm_ready", w0_dm_ready, 1'b1);
        chk("w0/ld2_if_ready", w0_if_ready, 1'b0);
        chk("w0/ld2_dm_rdata", w0_dm_rdata, hashw(20'h11));
        @(posedge clk);
        @(negedge clk);
        chk("w0/ld3_dm_ready", w0_dm_ready, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
